// File: rtl/xbar_slave_port_ctrl.sv
// Per-slave transaction controller for the 2-master crossbar: round-robin grant,
// registered slave command, ack/timeout handling and routing of the completion to the owner.
module xbar_slave_port_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        owner
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("xbar_slave_port_ctrl: TIMEOUT must lie in 2..255");
  end

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                last_m1_r, last_m1_s;
  logic [7:0]          cnt_r, cnt_s;
  logic                s_req_r, s_req_s;
  logic                s_we_r, s_we_s;
  logic [ADDR_W-1:0]   s_addr_r, s_addr_s;
  logic [DATA_W-1:0]   s_wdata_r, s_wdata_s;
  logic [1:0]          owner_r, owner_s;
  logic                m0_ack_r, m0_ack_s, m1_ack_r, m1_ack_s;
  logic                m0_err_r, m0_err_s, m1_err_r, m1_err_s;
  logic [DATA_W-1:0]   m0_rdata_r, m0_rdata_s, m1_rdata_r, m1_rdata_s;
  logic                grant_m1_s;
  logic                done_s;
  logic                done_err_s;
  logic [DATA_W-1:0]   done_rdata_s;

  // Next-state and next-output logic for the IDLE/BUSY/DONE transaction sequence
  always_comb begin
    state_s      = state_r;
    last_m1_s    = last_m1_r;
    cnt_s        = cnt_r;
    s_req_s      = s_req_r;
    s_we_s       = s_we_r;
    s_addr_s     = s_addr_r;
    s_wdata_s    = s_wdata_r;
    owner_s      = owner_r;
    m0_ack_s     = 1'b0;
    m1_ack_s     = 1'b0;
    m0_err_s     = m0_err_r;
    m1_err_s     = m1_err_r;
    m0_rdata_s   = m0_rdata_r;
    m1_rdata_s   = m1_rdata_r;
    grant_m1_s   = 1'b0;
    done_s       = 1'b0;
    done_err_s   = 1'b0;
    done_rdata_s = '0;

    case (state_r)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that was not served last wins
          grant_m1_s = m1_req && (!m0_req || !last_m1_r);
          if (grant_m1_s) begin
            s_we_s    = m1_we;
            s_addr_s  = m1_addr;
            s_wdata_s = m1_wdata;
            owner_s   = 2'b10;
          end else begin
            s_we_s    = m0_we;
            s_addr_s  = m0_addr;
            s_wdata_s = m0_wdata;
            owner_s   = 2'b01;
          end
          last_m1_s = grant_m1_s;
          s_req_s   = 1'b1;
          cnt_s     = 8'd0;
          state_s   = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (s_ack) begin
          done_s       = 1'b1;
          done_rdata_s = s_rdata;
          done_err_s   = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
          done_s       = 1'b1;
          done_rdata_s = '0;
          done_err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        s_req_s = 1'b0;
        owner_s = 2'b00;
      end
    endcase

    // Completion is routed only to the master that owns the transaction
    if (done_s) begin
      if (owner_r[1]) begin
        m1_ack_s   = 1'b1;
        m1_err_s   = done_err_s;
        m1_rdata_s = done_rdata_s;
      end else begin
        m0_ack_s   = 1'b1;
        m0_err_s   = done_err_s;
        m0_rdata_s = done_rdata_s;
      end
      s_req_s = 1'b0;
      owner_s = 2'b00;
      state_s = ST_DONE;
    end else begin
      done_err_s = 1'b0;
    end
  end

  // State and output registers; reset abandons any transaction without an ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_m1_r  <= 1'b1;
      cnt_r      <= 8'd0;
      s_req_r    <= 1'b0;
      s_we_r     <= 1'b0;
      s_addr_r   <= '0;
      s_wdata_r  <= '0;
      owner_r    <= 2'b00;
      m0_ack_r   <= 1'b0;
      m1_ack_r   <= 1'b0;
      m0_err_r   <= 1'b0;
      m1_err_r   <= 1'b0;
      m0_rdata_r <= '0;
      m1_rdata_r <= '0;
    end else begin
      state_r    <= state_s;
      last_m1_r  <= last_m1_s;
      cnt_r      <= cnt_s;
      s_req_r    <= s_req_s;
      s_we_r     <= s_we_s;
      s_addr_r   <= s_addr_s;
      s_wdata_r  <= s_wdata_s;
      owner_r    <= owner_s;
      m0_ack_r   <= m0_ack_s;
      m1_ack_r   <= m1_ack_s;
      m0_err_r   <= m0_err_s;
      m1_err_r   <= m1_err_s;
      m0_rdata_r <= m0_rdata_s;
      m1_rdata_r <= m1_rdata_s;
    end
  end

  assign s_req    = s_req_r;
  assign s_we     = s_we_r;
  assign s_addr   = s_addr_r;
  assign s_wdata  = s_wdata_r;
  assign owner    = owner_r;
  assign m0_ack   = m0_ack_r;
  assign m0_err   = m0_err_r;
  assign m0_rdata = m0_rdata_r;
  assign m1_ack   = m1_ack_r;
  assign m1_err   = m1_err_r;
  assign m1_rdata = m1_rdata_r;

endmodule

// File: tb/tb_xbar_slave_port_ctrl.sv
// Self-checking bench for xbar_slave_port_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model of grant, latency and completion.
module tb_xbar_slave_port_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic        s_ack = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  owner;

  int n_cmp = 0;
  int n_fail = 0;

  // model state: who was served last, and the held completion values per master
  int          mdl_last;
  logic [31:0] mdl_rd [2];
  logic        mdl_err [2];

  typedef struct {
    bit          granted;
    int          grant_lat;
    logic [1:0]  own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          stable;
    bit          acked;
    int          lat;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        done_sreq;
    logic [1:0]  done_owner;
    logic        post0, post1;
  } obs_t;

  xbar_slave_port_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_winner(bit r0, bit r1);
    if (r0 && r1) return (mdl_last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  function automatic bit model_in_time(int ack_after);
    return (ack_after >= 1) && (ack_after <= TO);
  endfunction

  task automatic model_commit(int w, int ack_after, logic [31:0] srd);
    mdl_last = w;
    mdl_rd[w]  = model_in_time(ack_after) ? srd : 32'h0;
    mdl_err[w] = !model_in_time(ack_after);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    mdl_last = 1;
    mdl_rd[0] = '0; mdl_rd[1] = '0; mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
  endtask

  // Drives one transaction from IDLE back to IDLE and records what the DUT did
  task automatic run_txn(input bit r0, input bit r1, input bit we0, input bit we1,
                         input logic [31:0] a0, input logic [31:0] w0,
                         input logic [31:0] a1, input logic [31:0] w1,
                         input int ack_after, input logic [31:0] srd, input bit hold,
                         output obs_t o);
    o = '{default: 0};
    o.stable = 1'b1;
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = w0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = w1;
    s_ack = 1'b0;
    for (int i = 0; i < 4 && !o.granted; i++) begin
      step();
      o.grant_lat = i + 1;
      if (s_req === 1'b1) o.granted = 1'b1;
    end
    if (o.granted) begin
      o.own = owner; o.we = s_we; o.addr = s_addr; o.wdata = s_wdata;
      for (int k = 1; k <= 300 && !o.acked; k++) begin
        s_ack   = (k == ack_after);
        s_rdata = (k == ack_after) ? srd : $urandom;
        m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom);
        m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom);
        step();
        if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
          o.acked = 1'b1; o.lat = k;
          o.ack0 = m0_ack; o.ack1 = m1_ack; o.err0 = m0_err; o.err1 = m1_err;
          o.rd0 = m0_rdata; o.rd1 = m1_rdata;
          o.done_sreq = s_req; o.done_owner = owner;
        end else if (s_addr !== o.addr || s_wdata !== o.wdata || s_we !== o.we) begin
          o.stable = 1'b0;
        end else begin
          o.stable = o.stable;
        end
      end
      s_ack = 1'b0;
      if (o.acked) begin
        if (!hold) begin
          m0_req = 1'b0; m1_req = 1'b0;
        end
        step();
        o.post0 = m0_ack; o.post1 = m1_ack;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if ({s_req, owner, m0_ack, m1_ack} !== 5'b0) begin n_fail++;
      $display("FAIL reset_ctrl act=%b exp=00000", {s_req, owner, m0_ack, m1_ack}); end
    n_cmp++; if ({m0_err, m1_err, s_we} !== 3'b0) begin n_fail++;
      $display("FAIL reset_flags act=%b exp=000", {m0_err, m1_err, s_we}); end
    n_cmp++; if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== 128'h0) begin n_fail++;
      $display("FAIL reset_data act=%h exp=0", {s_addr, s_wdata, m0_rdata, m1_rdata}); end
  endtask

  task automatic test_single_write();
    obs_t o;
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'h0, 32'h0, 3, 32'hDEAD0001, 1'b0, o);
    n_cmp++; if (o.grant_lat !== 1 || o.own !== 2'b01) begin n_fail++;
      $display("FAIL sw_grant act=lat%0d own%b exp=lat1 own01", o.grant_lat, o.own); end
    n_cmp++; if (o.addr !== 32'h10 || o.wdata !== 32'hA5A5A5A5 || o.we !== 1'b1) begin n_fail++;
      $display("FAIL sw_cmd act=%h/%h/%b exp=10/a5a5a5a5/1", o.addr, o.wdata, o.we); end
    n_cmp++; if (o.lat !== 3 || o.ack0 !== 1'b1 || o.ack1 !== 1'b0 || o.err0 !== 1'b0) begin n_fail++;
      $display("FAIL sw_ack act=lat%0d a%b%b e%b exp=lat3 a10 e0", o.lat, o.ack0, o.ack1, o.err0); end
    n_cmp++; if (o.post0 !== 1'b0 || o.post1 !== 1'b0) begin n_fail++;
      $display("FAIL sw_pulse act=%b%b exp=00", o.post0, o.post1); end
    model_commit(0, 3, 32'hDEAD0001);
  endtask

  task automatic test_fairness();
    obs_t o;
    logic [1:0] exp_own;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d = $urandom;
      int w = model_winner(1'b1, 1'b1);
      exp_own = (w == 1) ? 2'b10 : 2'b01;
      run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + i, 32'h0, 32'h200 + i, 32'h0, 1, d, 1'b1, o);
      n_cmp++; if (o.own !== exp_own || o.addr !== ((w == 1) ? 32'h200 + i : 32'h100 + i)) begin n_fail++;
        $display("FAIL rr_grant%0d act=own%b addr%h exp=own%b", i, o.own, o.addr, exp_own); end
      n_cmp++; if ({o.ack1, o.ack0} !== exp_own || o.lat !== 1) begin n_fail++;
        $display("FAIL rr_ack%0d act=%b%b lat%0d exp=%b lat1", i, o.ack1, o.ack0, o.lat, exp_own); end
      model_commit(w, 1, d);
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_read_m1();
    obs_t o;
    logic [31:0] keep0 = mdl_rd[0];
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h20, 32'h0, 2, 32'h12345678, 1'b0, o);
    n_cmp++; if (o.own !== 2'b10 || o.addr !== 32'h20 || o.we !== 1'b0) begin n_fail++;
      $display("FAIL rd_cmd act=own%b %h we%b exp=own10 20 we0", o.own, o.addr, o.we); end
    n_cmp++; if (o.ack1 !== 1'b1 || o.ack0 !== 1'b0 || o.rd1 !== 32'h12345678) begin n_fail++;
      $display("FAIL rd_data act=a%b%b %h exp=a10 12345678", o.ack1, o.ack0, o.rd1); end
    n_cmp++; if (o.rd0 !== keep0) begin n_fail++;
      $display("FAIL rd_other act=%h exp=%h", o.rd0, keep0); end
    model_commit(1, 2, 32'h12345678);
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0, -1, 32'h0, 1'b0, o);
    n_cmp++; if (o.lat !== TO || o.ack0 !== 1'b1 || o.err0 !== 1'b1 || o.rd0 !== 32'h0) begin n_fail++;
      $display("FAIL to_abort act=lat%0d a%b e%b rd%h exp=lat%0d a1 e1 rd0", o.lat, o.ack0, o.err0, o.rd0, TO); end
    n_cmp++; if (o.done_sreq !== 1'b0 || o.done_owner !== 2'b00 || o.ack1 !== 1'b0) begin n_fail++;
      $display("FAIL to_release act=sreq%b own%b a1%b exp=0 00 0", o.done_sreq, o.done_owner, o.ack1); end
    model_commit(0, -1, 32'h0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 32'h0, TO, 32'hCAFEF00D, 1'b0, o);
    n_cmp++; if (o.lat !== TO || o.err0 !== 1'b0 || o.rd0 !== 32'hCAFEF00D) begin n_fail++;
      $display("FAIL to_edge act=lat%0d e%b rd%h exp=lat%0d e0 cafef00d", o.lat, o.err0, o.rd0, TO); end
    model_commit(0, TO, 32'hCAFEF00D);
  endtask

  task automatic test_stable_and_stale();
    obs_t o;
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h77, 32'h5555AAAA, 32'h0, 32'h0, 6, 32'h0BADBEEF, 1'b0, o);
    n_cmp++; if (o.stable !== 1'b1 || o.addr !== 32'h77 || o.wdata !== 32'h5555AAAA) begin n_fail++;
      $display("FAIL busy_hold act=st%b %h/%h exp=st1 77/5555aaaa", o.stable, o.addr, o.wdata); end
    model_commit(0, 6, 32'h0BADBEEF);
    s_ack = 1'b1; s_rdata = 32'h13572468;
    step();
    s_ack = 1'b0;
    step();
    n_cmp++; if ({m0_ack, m1_ack, s_req} !== 3'b000 || m0_rdata !== mdl_rd[0] || m1_rdata !== mdl_rd[1]) begin n_fail++;
      $display("FAIL stale_ack act=%b%b%b %h %h exp=000 %h %h", m0_ack, m1_ack, s_req, m0_rdata, m1_rdata, mdl_rd[0], mdl_rd[1]); end
  endtask

  task automatic test_reset_busy();
    obs_t o;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h99; m0_wdata = 32'h1;
    step(); step();
    n_cmp++; if (s_req !== 1'b1) begin n_fail++;
      $display("FAIL rb_busy act=%b exp=1", s_req); end
    reset = 1'b1; m0_req = 1'b0;
    step();
    reset = 1'b0;
    n_cmp++; if ({s_req, owner, m0_ack, m1_ack, m0_err, m1_err} !== 7'b0 || {s_addr, m0_rdata, m1_rdata} !== 96'h0) begin n_fail++;
      $display("FAIL rb_clear act=%b %h exp=0 0", {s_req, owner, m0_ack, m1_ack, m0_err, m1_err}, {s_addr, m0_rdata, m1_rdata}); end
    mdl_last = 1; mdl_rd[0] = '0; mdl_rd[1] = '0; mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, 32'h2, 32'h0, 1, 32'h3, 1'b0, o);
    n_cmp++; if (o.own !== 2'b01 || o.ack0 !== 1'b1) begin n_fail++;
      $display("FAIL rb_tie act=own%b a0%b exp=own01 a01", o.own, o.ack0); end
    model_commit(0, 1, 32'h3);
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 30; n++) begin
      bit r0 = 1'($urandom), r1 = 1'($urandom);
      logic [31:0] a0 = $urandom, w0 = $urandom, a1 = $urandom, w1 = $urandom, d = $urandom;
      bit we0 = 1'($urandom), we1 = 1'($urandom);
      int aa = $urandom_range(0, TO + 2);
      int w, exp_lat, o_w;
      if (!r0 && !r1) r0 = 1'b1;
      if (aa == 0) aa = -1;
      w = model_winner(r0, r1);
      exp_lat = model_in_time(aa) ? aa : TO;
      run_txn(r0, r1, we0, we1, a0, w0, a1, w1, aa, d, 1'($urandom), o);
      n_cmp++; if (o.own !== ((w == 1) ? 2'b10 : 2'b01) || o.grant_lat !== 1) begin n_fail++;
        $display("FAIL rnd%0d_grant act=own%b lat%0d exp=m%0d lat1", n, o.own, o.grant_lat, w); end
      n_cmp++; if (o.addr !== ((w == 1) ? a1 : a0) || o.wdata !== ((w == 1) ? w1 : w0) ||
                   o.we !== ((w == 1) ? we1 : we0) || o.stable !== 1'b1) begin n_fail++;
        $display("FAIL rnd%0d_cmd act=%h/%h/%b st%b exp=m%0d values", n, o.addr, o.wdata, o.we, o.stable, w); end
      n_cmp++; if (o.acked !== 1'b1 || o.lat !== exp_lat || {o.ack1, o.ack0} !== ((w == 1) ? 2'b10 : 2'b01)) begin n_fail++;
        $display("FAIL rnd%0d_ack act=lat%0d a%b%b exp=lat%0d m%0d", n, o.lat, o.ack1, o.ack0, exp_lat, w); end
      model_commit(w, aa, d);
      o_w = 1 - w;
      n_cmp++; if (o.rd0 !== mdl_rd[0] || o.rd1 !== mdl_rd[1] || o.err0 !== mdl_err[0] || o.err1 !== mdl_err[1]) begin n_fail++;
        $display("FAIL rnd%0d_data act=%h %h e%b%b exp=%h %h e%b%b (other m%0d)", n, o.rd0, o.rd1, o.err0, o.err1,
                 mdl_rd[0], mdl_rd[1], mdl_err[0], mdl_err[1], o_w); end
      n_cmp++; if (o.post0 !== 1'b0 || o.post1 !== 1'b0 || o.done_sreq !== 1'b0 || o.done_owner !== 2'b00) begin n_fail++;
        $display("FAIL rnd%0d_done act=p%b%b sreq%b own%b exp=p00 0 00", n, o.post0, o.post1, o.done_sreq, o.done_owner); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_read_m1();
    test_timeout();
    test_stable_and_stale();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
